// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler.
// The result struct is sized for up to 256 channels and a 32-bit frequency.
package fft_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENG_RST,
        FILL,
        WAIT_PEAK,
        REPORT
    } sched_state_t;

    localparam int ENG_RST_CYCLES = 2;
    localparam int RES_CH_W       = 8;
    localparam int RES_FREQ_W     = 32;

    typedef struct packed {
        logic [RES_CH_W-1:0]   ch;
        logic [RES_FREQ_W-1:0] freq;
        logic                  timeout;
    } sched_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted index.
// The pointer resets to N-1 so index 0 has first priority.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [N-1:0]     req_in,
    input  logic             advance_in,
    output logic [N-1:0]     grant_out,
    output logic [IDX_W-1:0] grant_idx_out
);

    logic [IDX_W-1:0] ptr_q;
    int               idx;
    logic             found;

    always_comb begin
        grant_out     = '0;
        grant_idx_out = '0;
        found         = 1'b0;
        idx           = 0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req_in[idx]) begin
                found          = 1'b1;
                grant_out[idx] = 1'b1;
                grant_idx_out  = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr_q <= IDX_W'(N - 1);
        end else if (advance_in && found) begin
            ptr_q <= grant_idx_out;
        end
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Time-shares one FFT peak-detect engine between NUM_CH channels, one frame at a time.
// Optional FFT_SCHED_CH_MASK_EN adds ch_mask_in to restrict which channels are eligible.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter  int NUM_CH         = 4,
    parameter  int FFT_SIZE       = 2048,
    parameter  int SAMPLE_W       = 32,
    parameter  int FREQ_W         = 32,
    parameter  int TIMEOUT_CYCLES = 8192,
    localparam int CH_W           = $clog2(NUM_CH)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [NUM_CH-1:0]          ch_valid_in,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_sample_in,
`ifdef FFT_SCHED_CH_MASK_EN
    input  logic [NUM_CH-1:0]          ch_mask_in,
`endif
    output logic [NUM_CH-1:0]          ch_ready_out,
    output logic                       eng_rst_out,
    output logic                       eng_ce_out,
    output logic [SAMPLE_W-1:0]        eng_sample_out,
    input  logic [FREQ_W-1:0]          eng_peak_freq_in,
    input  logic                       eng_peak_valid_in,
    output logic                       res_valid_out,
    output logic [CH_W-1:0]            res_ch_out,
    output logic [FREQ_W-1:0]          res_freq_out,
    output logic                       res_timeout_out,
    output logic                       busy_out
);

    localparam int               CNT_W       = $clog2(FFT_SIZE);
    localparam int               TO_W        = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(FFT_SIZE - 1);
    localparam logic [TO_W-1:0]  LAST_WAIT   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       RST_LAST    = 2'(ENG_RST_CYCLES - 1);

    logic [1:0]        rst_sync_q;
    logic              rst_n_int;
    sched_state_t      state_q;
    logic [CH_W-1:0]   sel_q;
    logic [NUM_CH-1:0] sel_oh_q;
    logic [1:0]        rst_cnt_q;
    logic [CNT_W-1:0]  sample_cnt_q;
    logic [TO_W-1:0]   wait_cnt_q;
    logic [NUM_CH-1:0] ready_q;
    logic              eng_rst_q;
    logic              res_valid_q;
    sched_result_t     result_q;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              in_fill;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rst_sync_q <= '0;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

`ifdef FFT_SCHED_CH_MASK_EN
    assign eligible = ch_valid_in & ch_mask_in;
`else
    assign eligible = ch_valid_in;
`endif

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_int),
        .req_in        (eligible),
        .advance_in    (state_q == IDLE),
        .grant_out     (grant),
        .grant_idx_out (grant_idx)
    );

    assign in_fill         = (state_q == FILL);
    assign eng_ce_out      = in_fill & ch_valid_in[sel_q];
    assign eng_sample_out  = in_fill ? ch_sample_in[sel_q*SAMPLE_W +: SAMPLE_W] : '0;
    assign ch_ready_out    = ready_q;
    assign eng_rst_out     = eng_rst_q;
    assign res_valid_out   = res_valid_q;
    assign res_ch_out      = result_q.ch[CH_W-1:0];
    assign res_freq_out    = result_q.freq[FREQ_W-1:0];
    assign res_timeout_out = result_q.timeout;
    assign busy_out        = (state_q != IDLE);

    always_ff @(posedge clk_in or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            sel_oh_q     <= '0;
            rst_cnt_q    <= '0;
            sample_cnt_q <= '0;
            wait_cnt_q   <= '0;
            ready_q      <= '0;
            eng_rst_q    <= 1'b1;
            res_valid_q  <= 1'b0;
            result_q     <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                // The sample strobe that wins the grant is dropped on purpose.
                IDLE: begin
                    eng_rst_q <= |eligible;
                    if (|eligible) begin
                        sel_q     <= grant_idx;
                        sel_oh_q  <= grant;
                        rst_cnt_q <= '0;
                        state_q   <= ENG_RST;
                    end
                end
                ENG_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        eng_rst_q    <= 1'b0;
                        ready_q      <= sel_oh_q;
                        sample_cnt_q <= '0;
                        state_q      <= FILL;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 2'd1;
                    end
                end
                FILL: begin
                    if (eng_ce_out) begin
                        if (sample_cnt_q == LAST_SAMPLE) begin
                            ready_q    <= '0;
                            wait_cnt_q <= '0;
                            state_q    <= WAIT_PEAK;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 1'b1;
                        end
                    end
                end
                // A peak arriving on the final timeout cycle still counts as a real result.
                WAIT_PEAK: begin
                    if (eng_peak_valid_in) begin
                        result_q.ch      <= RES_CH_W'(sel_q);
                        result_q.freq    <= RES_FREQ_W'(eng_peak_freq_in);
                        result_q.timeout <= 1'b0;
                        res_valid_q      <= 1'b1;
                        state_q          <= REPORT;
                    end else if (wait_cnt_q == LAST_WAIT) begin
                        result_q.ch      <= RES_CH_W'(sel_q);
                        result_q.freq    <= '0;
                        result_q.timeout <= 1'b1;
                        res_valid_q      <= 1'b1;
                        state_q          <= REPORT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                REPORT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler with a behavioural peak-detect engine.
// Define FFT_SCHED_CH_MASK_EN to also exercise the channel mask.
module tb_fft_frame_scheduler;

    localparam int NUM_CH   = 4;
    localparam int FFT_SIZE = 16;
    localparam int SAMPLE_W = 32;
    localparam int FREQ_W   = 32;
    localparam int TIMEOUT  = 64;

    typedef struct {
        int          ch;
        logic [31:0] freq;
        logic        timeout;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rstN = 1'b1;
    logic [NUM_CH-1:0]          chValid = '0;
    logic [NUM_CH*SAMPLE_W-1:0] chSample = '0;
    logic [NUM_CH-1:0]          chMask = '1;
    logic [NUM_CH-1:0]          chReady;
    logic                       engRst;
    logic                       engCe;
    logic [SAMPLE_W-1:0]        engSample;
    logic [FREQ_W-1:0]          peakFreq = '0;
    logic                       peakValid = 1'b0;
    logic                       resValid;
    logic [1:0]                 resCh;
    logic [FREQ_W-1:0]          resFreq;
    logic                       resTimeout;
    logic                       busy;

    exp_t sb[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    logic [NUM_CH-1:0] strobeEn = '0;
    int   phase = 0;
    int   sampleIdx = 0;
    bit   peakEnable = 1'b1;
    int   peakLat = 40;
    bit   fixedFreq = 1'b0;
    bit   injectStray = 1'b0;
    int   engCeCnt = 0;
    int   pend = 0;
    int   frameCe = 0;
    bit   inFrame = 1'b0;

    always #5 clk = ~clk;

    fft_frame_scheduler #(
        .NUM_CH(NUM_CH), .FFT_SIZE(FFT_SIZE), .SAMPLE_W(SAMPLE_W),
        .FREQ_W(FREQ_W), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rstN),
        .ch_valid_in       (chValid),
        .ch_sample_in      (chSample),
`ifdef FFT_SCHED_CH_MASK_EN
        .ch_mask_in        (chMask),
`endif
        .ch_ready_out      (chReady),
        .eng_rst_out       (engRst),
        .eng_ce_out        (engCe),
        .eng_sample_out    (engSample),
        .eng_peak_freq_in  (peakFreq),
        .eng_peak_valid_in (peakValid),
        .res_valid_out     (resValid),
        .res_ch_out        (resCh),
        .res_freq_out      (resFreq),
        .res_timeout_out   (resTimeout),
        .busy_out          (busy)
    );

    // Enabled channels strobe together every 4 cycles; samples carry a channel tag.
    initial forever begin
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
        for (int c = 0; c < NUM_CH; c++) begin
            chValid[c] = strobeEn[c] && (phase == 0);
            chSample[c*SAMPLE_W +: SAMPLE_W] = {8'hC0, 8'(c), 16'(sampleIdx)};
        end
        if (phase == 0) sampleIdx++;
    end

    // Engine model: reports the tag of its last sample peakLat cycles after the 16th ce.
    initial forever begin
        @(negedge clk);
        peakValid = 1'b0;
        if (injectStray) begin
            peakValid   = 1'b1;
            peakFreq    = 32'hDEAD;
            injectStray = 1'b0;
        end
        if (engRst) begin
            engCeCnt = 0;
            pend     = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) peakValid = 1'b1;
            end
            if (engCe) begin
                engCeCnt++;
                if (engCeCnt == FFT_SIZE) begin
                    engCeCnt = 0;
                    peakFreq = fixedFreq ? 32'h1234 : {16'h0, engSample[31:16]};
                    if (peakEnable) pend = peakLat;
                end
            end
        end
    end

    // Result scoreboard and per-frame ce counting.
    always @(negedge clk) begin
        if (resValid) begin
            testsRun++;
            if (sb.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected_result ch=%0d freq=%h timeout=%b required no result", resCh, resFreq, resTimeout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'(resCh) !== e.ch || resFreq !== e.freq || resTimeout !== e.timeout) begin
                    testsFailed++;
                    $display("[TB] FAIL result got ch=%0d freq=%h to=%b required ch=%0d freq=%h to=%b",
                             resCh, resFreq, resTimeout, e.ch, e.freq, e.timeout);
                end
            end
        end
        if (!rstN) begin
            inFrame = 1'b0;
            frameCe = 0;
        end else if (chReady != '0) begin
            inFrame = 1'b1;
            if (engCe) frameCe++;
        end else if (inFrame) begin
            testsRun++;
            if (frameCe !== FFT_SIZE) begin
                testsFailed++;
                $display("[TB] FAIL frame_ce_count got %0d required %0d", frameCe, FFT_SIZE);
            end
            inFrame = 1'b0;
            frameCe = 0;
        end
    end

    // Lets queued frames complete, stopping strobes once the last frame has been filled.
    task automatic applyStimulus(input int budget, output bit ok);
        int cyc = 0;
        while (sb.size() > 1 && cyc < budget) begin @(negedge clk); cyc++; end
        while (chReady == '0 && cyc < budget) begin @(negedge clk); cyc++; end
        while (chReady != '0 && cyc < budget) begin @(negedge clk); cyc++; end
        strobeEn = '0;
        while (sb.size() > 0 && cyc < budget) begin @(negedge clk); cyc++; end
        repeat (4) @(negedge clk);
        ok = (cyc < budget);
        if (!ok) begin
            sb.delete();
            strobeEn = '0;
        end
    endtask

    task automatic test_reset();
        #2 rstN = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (engRst !== 1'b1 || chReady !== '0 || engCe !== 1'b0 || engSample !== '0 ||
            resValid !== 1'b0 || resCh !== '0 || resFreq !== '0 || resTimeout !== 1'b0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs got rst=%b rdy=%b ce=%b smp=%h rv=%b ch=%0d f=%h to=%b busy=%b required rst=1 others 0",
                     engRst, chReady, engCe, engSample, resValid, resCh, resFreq, resTimeout, busy);
        end
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        testsRun++;
        if (engRst !== 1'b0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_after_reset got eng_rst=%b busy=%b required 0 0", engRst, busy);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        for (int k = 0; k < 8; k++) sb.push_back('{k % 4, 32'hC000 | (k % 4), 1'b0});
        strobeEn = 4'hF;
        applyStimulus(4000, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL round_robin_done got timeout required 8 results");
        end
    endtask

    task automatic test_single_channel();
        bit ok;
        int cyc = 0;
        int rstCycles = 0;
        fixedFreq = 1'b1;
        sb.push_back('{2, 32'h1234, 1'b0});
        strobeEn = 4'b0100;
        while (!engRst && cyc < 200) begin @(negedge clk); cyc++; end
        while (engRst && cyc < 200) begin rstCycles++; @(negedge clk); cyc++; end
        testsRun++;
        if (rstCycles !== 2) begin
            testsFailed++;
            $display("[TB] FAIL eng_rst_width got %0d required 2", rstCycles);
        end
        testsRun++;
        if (chReady !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL ready_after_rst got %b required 0100", chReady);
        end
        applyStimulus(2000, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL single_channel_done got timeout required 1 result");
        end
        fixedFreq = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc = 0;
        int lat = 0;
        peakEnable = 1'b0;
        sb.push_back('{3, 32'h0, 1'b1});
        sb.push_back('{3, 32'hC003, 1'b0});
        strobeEn = 4'b1000;
        while (chReady == '0 && cyc < 500) begin @(negedge clk); cyc++; end
        while (chReady != '0 && cyc < 500) begin @(negedge clk); cyc++; end
        while (!resValid && lat < 200) begin @(negedge clk); lat++; end
        testsRun++;
        if (lat !== TIMEOUT) begin
            testsFailed++;
            $display("[TB] FAIL timeout_latency got %0d required %0d", lat, TIMEOUT);
        end
        peakEnable = 1'b1;
        applyStimulus(2000, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL timeout_recovery got timeout required 2 results");
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int cyc = 0;
        int ces = 0;
        strobeEn = 4'b0010;
        while (chReady == '0 && cyc < 500) begin @(negedge clk); cyc++; end
        while (ces < 10 && cyc < 500) begin
            if (engCe) ces++;
            if (ces < 10) begin @(negedge clk); cyc++; end
        end
        #1 rstN = 1'b0;
        #1;
        strobeEn = '0;
        testsRun++;
        if (engRst !== 1'b1 || chReady !== '0 || engCe !== 1'b0 || engSample !== '0 ||
            busy !== 1'b0 || resValid !== 1'b0 || resFreq !== '0 || resTimeout !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midframe_reset got rst=%b rdy=%b ce=%b smp=%h busy=%b rv=%b f=%h to=%b required rst=1 others 0",
                     engRst, chReady, engCe, engSample, busy, resValid, resFreq, resTimeout);
        end
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        sb.push_back('{0, 32'hC000, 1'b0});
        strobeEn = 4'hF;
        applyStimulus(2000, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_frame got timeout required 1 result");
        end
    endtask

    task automatic test_coincide();
        bit ok;
        int cyc = 0;
        peakLat = TIMEOUT;
        sb.push_back('{0, 32'hC000, 1'b0});
        strobeEn = 4'b0001;
        while (chReady == '0 && cyc < 500) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        injectStray = 1'b1;
        applyStimulus(2000, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL coincide_done got timeout required 1 result");
        end
        peakLat = 40;
    endtask

`ifdef FFT_SCHED_CH_MASK_EN
    task automatic test_mask();
        bit ok;
        bit sawBusy = 1'b0;
        chMask = 4'b1010;
        for (int k = 0; k < 4; k++) sb.push_back('{(k % 2) ? 3 : 1, 32'hC000 | ((k % 2) ? 3 : 1), 1'b0});
        strobeEn = 4'hF;
        applyStimulus(3000, ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL mask_alternate got timeout required 4 results");
        end
        chMask = 4'b0000;
        strobeEn = 4'hF;
        repeat (80) begin
            @(negedge clk);
            if (busy) sawBusy = 1'b1;
        end
        strobeEn = '0;
        testsRun++;
        if (sawBusy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mask_zero_busy got %b required 0", sawBusy);
        end
        chMask = '1;
    endtask
`endif

    task automatic checkOutput();
        testsRun++;
        if (sb.size() !== 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_empty got %0d pending required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_channel();
        test_timeout();
        test_reset_mid_frame();
        test_coincide();
`ifdef FFT_SCHED_CH_MASK_EN
        test_mask();
`endif
        checkOutput();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got no completion required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
